// File: rtl/issue_unit.sv
// Issue arbiter for four execution units sharing one CDB.
// Grants at most one unit per cycle and books its future CDB slot.
module issue_unit #(
    parameter int INT_LAT   = 1,
    parameter int LD_ST_LAT = 2,
    parameter int MULT_LAT  = 4,
    parameter int DIV_LAT   = 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_int_ready,
    input  logic       i_ld_st_ready,
    input  logic       i_mult_ready,
    input  logic       i_div_ready,
    output logic       o_int_rd,
    output logic       o_ld_st_rd,
    output logic       o_mult_rd,
    output logic       o_div_rd,
    output logic       o_cdb_slot_valid,
    output logic [1:0] o_cdb_owner,
    output logic       o_div_busy
);

    localparam logic [1:0] OWN_INT   = 2'd0;
    localparam logic [1:0] OWN_LD_ST = 2'd1;
    localparam logic [1:0] OWN_MULT  = 2'd2;
    localparam logic [1:0] OWN_DIV   = 2'd3;

    // Latencies are limited to 1..7 so every index fits in 3 bits.
    localparam logic [2:0] INT_IDX   = 3'(INT_LAT);
    localparam logic [2:0] LD_ST_IDX = 3'(LD_ST_LAT);
    localparam logic [2:0] MULT_IDX  = 3'(MULT_LAT);
    localparam logic [2:0] DIV_IDX   = 3'(DIV_LAT);
    localparam logic [2:0] DIV_RELOAD = 3'(DIV_LAT - 1);

    typedef struct packed {
        logic       vld;
        logic [2:0] slot;
        logic [1:0] owner;
    } book_t;

    logic [7:0]      sched, sched_nxt;
    logic [7:0][1:0] own, own_nxt;
    logic [2:0]      div_cnt;
    logic            lru;
    logic            int_ok, ld_st_ok, mult_ok, div_ok;
    book_t           bk;

    assign int_ok   = i_int_ready   & ~sched[INT_IDX];
    assign ld_st_ok = i_ld_st_ready & ~sched[LD_ST_IDX];
    assign mult_ok  = i_mult_ready  & ~sched[MULT_IDX];
    assign div_ok   = i_div_ready   & ~sched[DIV_IDX] & (div_cnt == 3'd0);

    always_comb begin
        o_int_rd   = 1'b0;
        o_ld_st_rd = 1'b0;
        o_mult_rd  = 1'b0;
        o_div_rd   = 1'b0;
        bk         = '0;
        if (i_rst_n) begin
            if (div_ok) begin
                o_div_rd = 1'b1;
                bk       = '{1'b1, DIV_IDX - 3'd1, OWN_DIV};
            end else if (mult_ok) begin
                o_mult_rd = 1'b1;
                bk        = '{1'b1, MULT_IDX - 3'd1, OWN_MULT};
            end else if (int_ok && (!lru || !ld_st_ok)) begin
                o_int_rd = 1'b1;
                bk       = '{1'b1, INT_IDX - 3'd1, OWN_INT};
            end else if (ld_st_ok) begin
                o_ld_st_rd = 1'b1;
                bk         = '{1'b1, LD_ST_IDX - 3'd1, OWN_LD_ST};
            end
        end
    end

    // Slot L-1 of the shifted vector was slot L now, already checked free.
    always_comb begin
        sched_nxt = sched >> 1;
        own_nxt   = own >> 2;
        if (bk.vld) begin
            sched_nxt[bk.slot] = 1'b1;
            own_nxt[bk.slot]   = bk.owner;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sched   <= '0;
            own     <= '0;
            div_cnt <= '0;
            lru     <= 1'b0;
        end else begin
            sched <= sched_nxt;
            own   <= own_nxt;
            if (o_div_rd)
                div_cnt <= DIV_RELOAD;
            else if (div_cnt != 3'd0)
                div_cnt <= div_cnt - 3'd1;
            if (o_int_rd)
                lru <= 1'b1;
            else if (o_ld_st_rd)
                lru <= 1'b0;
        end
    end

    assign o_cdb_slot_valid = sched[0];
    assign o_cdb_owner      = sched[0] ? own[0] : 2'b00;
    assign o_div_busy       = (div_cnt != 3'd0);

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios plus randomized traffic
// checked against a timeline model of CDB bookings.
module tb_issue_unit;

    localparam int INT_LAT = 1, LD_ST_LAT = 2, MULT_LAT = 4, DIV_LAT = 7;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [3:0] rdy = 4'b0;   // {div, mult, ld_st, int}
    logic       i_int_ready, i_ld_st_ready, i_mult_ready, i_div_ready;
    logic       o_int_rd, o_ld_st_rd, o_mult_rd, o_div_rd;
    logic       o_cdb_slot_valid, o_div_busy;
    logic [1:0] o_cdb_owner;
    logic [3:0] rd;
    logic [2:0] cdb;

    int vectors = 0;
    int miscompares = 0;

    assign {i_div_ready, i_mult_ready, i_ld_st_ready, i_int_ready} = rdy;
    assign rd  = {o_div_rd, o_mult_rd, o_ld_st_rd, o_int_rd};
    assign cdb = {o_cdb_slot_valid, o_cdb_owner};

    issue_unit #(
        .INT_LAT(INT_LAT), .LD_ST_LAT(LD_ST_LAT),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_int_ready(i_int_ready), .i_ld_st_ready(i_ld_st_ready),
        .i_mult_ready(i_mult_ready), .i_div_ready(i_div_ready),
        .o_int_rd(o_int_rd), .o_ld_st_rd(o_ld_st_rd),
        .o_mult_rd(o_mult_rd), .o_div_rd(o_div_rd),
        .o_cdb_slot_valid(o_cdb_slot_valid), .o_cdb_owner(o_cdb_owner),
        .o_div_busy(o_div_busy)
    );

    always #5 i_clk = ~i_clk;

    // Leaves the bench at the start of cycle 0 (just after a negedge).
    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        rdy = 4'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        rdy = 4'hF;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (rd !== 4'b0) begin
                miscompares++;
                $display("FAIL reset_grants i=%0d got=%b want=0000", i, rd);
            end
            vectors++;
            if ({cdb, o_div_busy} !== 4'b0) begin
                miscompares++;
                $display("FAIL reset_cdb i=%0d got=%b want=0000", i, {cdb, o_div_busy});
            end
            @(posedge i_clk);
        end
        rdy = 4'b0;
    endtask

    task automatic test_int_stream();
        logic [2:0] exp;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge i_clk);
            rdy = 4'b0001;
            #1;
            exp = (c >= 1) ? 3'b100 : 3'b000;
            vectors++;
            if (rd !== 4'b0001) begin
                miscompares++;
                $display("FAIL int_stream_rd c=%0d got=%b want=0001", c, rd);
            end
            vectors++;
            if (cdb !== exp) begin
                miscompares++;
                $display("FAIL int_stream_cdb c=%0d got=%b want=%b", c, cdb, exp);
            end
        end
        rdy = 4'b0;
    endtask

    task automatic test_mult_int();
        logic [3:0] r_in [6] = '{4'b0100, 4'b0, 4'b0, 4'b0001, 4'b0001, 4'b0};
        logic [3:0] r_exp[6] = '{4'b0100, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0};
        logic [2:0] c_exp[6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b100};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge i_clk);
            rdy = r_in[c];
            #1;
            vectors++;
            if (rd !== r_exp[c]) begin
                miscompares++;
                $display("FAIL mult_int_rd c=%0d got=%b want=%b", c, rd, r_exp[c]);
            end
            vectors++;
            if (cdb !== c_exp[c]) begin
                miscompares++;
                $display("FAIL mult_int_cdb c=%0d got=%b want=%b", c, cdb, c_exp[c]);
            end
        end
        rdy = 4'b0;
    endtask

    task automatic test_div_spacing();
        logic grant_c, busy_c;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge i_clk);
            rdy = 4'b1000;
            #1;
            grant_c = (c % 7 == 0);
            busy_c  = (c % 7 != 0);
            vectors++;
            if (rd !== {grant_c, 3'b000}) begin
                miscompares++;
                $display("FAIL div_rd c=%0d got=%b want=%b", c, rd, {grant_c, 3'b000});
            end
            vectors++;
            if (o_div_busy !== busy_c) begin
                miscompares++;
                $display("FAIL div_busy c=%0d got=%b want=%b", c, o_div_busy, busy_c);
            end
            vectors++;
            if (cdb !== ((c == 7 || c == 14) ? 3'b111 : 3'b000)) begin
                miscompares++;
                $display("FAIL div_cdb c=%0d got=%b", c, cdb);
            end
        end
        rdy = 4'b0;
    endtask

    task automatic test_lru();
        logic [3:0] r_exp;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge i_clk);
            rdy = (c == 0 || c == 10) ? 4'b0011 : 4'b0000;
            #1;
            r_exp = (c == 0) ? 4'b0001 : (c == 10) ? 4'b0010 : 4'b0000;
            vectors++;
            if (rd !== r_exp) begin
                miscompares++;
                $display("FAIL lru_rd c=%0d got=%b want=%b", c, rd, r_exp);
            end
            if (c == 12) begin
                vectors++;
                if (cdb !== 3'b101) begin
                    miscompares++;
                    $display("FAIL lru_cdb c=%0d got=%b want=101", c, cdb);
                end
            end
        end
        rdy = 4'b0;
    endtask

    // Ready held until granted; ld_st is pushed back once by the mult booking.
    task automatic test_priority();
        logic [3:0] r_in [8] = '{4'hF, 4'h7, 4'h3, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
        logic [3:0] r_exp[8] = '{4'h8, 4'h4, 4'h1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
        logic [2:0] c_exp[8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000,
                                 3'b110, 3'b101, 3'b111};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge i_clk);
            rdy = r_in[c];
            #1;
            vectors++;
            if (rd !== r_exp[c]) begin
                miscompares++;
                $display("FAIL prio_rd c=%0d got=%b want=%b", c, rd, r_exp[c]);
            end
            vectors++;
            if (cdb !== c_exp[c]) begin
                miscompares++;
                $display("FAIL prio_cdb c=%0d got=%b want=%b", c, cdb, c_exp[c]);
            end
        end
        rdy = 4'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] r_exp;
        logic [2:0] c_exp;
        logic       b_exp;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge i_clk);
            if (c == 3) i_rst_n = 1'b0;
            if (c == 4) i_rst_n = 1'b1;
            rdy = (c == 0 || c == 3 || c == 4) ? 4'b1000 : 4'b0000;
            #1;
            r_exp = (c == 0 || c == 4) ? 4'b1000 : 4'b0000;
            b_exp = (c == 1 || c == 2 || (c >= 5 && c <= 10));
            c_exp = (c == 11) ? 3'b111 : 3'b000;
            vectors++;
            if (rd !== r_exp) begin
                miscompares++;
                $display("FAIL rstmid_rd c=%0d got=%b want=%b", c, rd, r_exp);
            end
            vectors++;
            if (o_div_busy !== b_exp) begin
                miscompares++;
                $display("FAIL rstmid_busy c=%0d got=%b want=%b", c, o_div_busy, b_exp);
            end
            vectors++;
            if (cdb !== c_exp) begin
                miscompares++;
                $display("FAIL rstmid_cdb c=%0d got=%b want=%b", c, cdb, c_exp);
            end
        end
        rdy = 4'b0;
    endtask

    // Model: absolute-cycle timeline of CDB bookings plus divider free time.
    task automatic test_random();
        localparam int N = 400;
        logic       booked[N + 8];
        logic [1:0] owner [N + 8];
        int         div_free;
        logic       prefer_ld;
        logic [3:0] r, r_exp;
        logic [2:0] c_exp;
        logic       busy, e_int, e_ld, e_mul, e_div;
        for (int i = 0; i < N + 8; i++) begin
            booked[i] = 1'b0;
            owner[i]  = 2'b00;
        end
        div_free  = 0;
        prefer_ld = 1'b0;
        do_reset();
        for (int t = 0; t < N; t++) begin
            if (t > 0) @(negedge i_clk);
            r = 4'($urandom_range(0, 15));
            rdy = r;
            #1;
            busy  = (t < div_free);
            e_int = r[0] && !booked[t + INT_LAT];
            e_ld  = r[1] && !booked[t + LD_ST_LAT];
            e_mul = r[2] && !booked[t + MULT_LAT];
            e_div = r[3] && !booked[t + DIV_LAT] && !busy;
            c_exp = booked[t] ? {1'b1, owner[t]} : 3'b000;
            r_exp = 4'b0;
            if (e_div) begin
                r_exp = 4'b1000;
                booked[t + DIV_LAT] = 1'b1; owner[t + DIV_LAT] = 2'd3;
                div_free = t + DIV_LAT;
            end else if (e_mul) begin
                r_exp = 4'b0100;
                booked[t + MULT_LAT] = 1'b1; owner[t + MULT_LAT] = 2'd2;
            end else if (e_int && (!prefer_ld || !e_ld)) begin
                r_exp = 4'b0001;
                booked[t + INT_LAT] = 1'b1; owner[t + INT_LAT] = 2'd0;
                prefer_ld = 1'b1;
            end else if (e_ld) begin
                r_exp = 4'b0010;
                booked[t + LD_ST_LAT] = 1'b1; owner[t + LD_ST_LAT] = 2'd1;
                prefer_ld = 1'b0;
            end
            vectors++;
            if (rd !== r_exp) begin
                miscompares++;
                $display("FAIL rand_rd t=%0d rdy=%b got=%b want=%b", t, r, rd, r_exp);
            end
            vectors++;
            if (cdb !== c_exp) begin
                miscompares++;
                $display("FAIL rand_cdb t=%0d got=%b want=%b", t, cdb, c_exp);
            end
            vectors++;
            if (o_div_busy !== busy) begin
                miscompares++;
                $display("FAIL rand_busy t=%0d got=%b want=%b", t, o_div_busy, busy);
            end
        end
        rdy = 4'b0;
    endtask

    initial begin
        test_reset();
        test_int_stream();
        test_mult_int();
        test_div_spacing();
        test_lru();
        test_priority();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
